mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter that serialises NUM_CH requester
// channels onto a single memory port with a fixed read latency of RD_LAT.
// Optional build macro MEM_ARB_CH0_PRIO_EN gives channel 0 absolute
// priority; the remaining channels then rotate among themselves.
//
// state | meaning
// IDLE  | arbitrate unmasked requests, capture the winner
// ISSUE | one-cycle memory strobe for the captured request
// WAIT  | count down RD_LAT cycles, capture read data on the last one
// RESP  | one-cycle completion pulse to the served channel
module mem_req_arbiter #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req_vld,
   input  logic [NUM_CH-1:0]        req_rd,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_wr_data,
   output logic [NUM_CH-1:0]        rsp_vld,
   output logic [DATA_W-1:0]        rsp_rd_data,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wr_data,
   input  logic [DATA_W-1:0]        mem_rd_data
);

   localparam int IDX_W = $clog2(NUM_CH);
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic [IDX_W-1:0]  grant;
   logic [IDX_W-1:0]  last_grant;
   logic              gnt_rd;
   logic [NUM_CH-1:0] mask;
   logic [CNT_W-1:0]  wait_cnt;
   logic [NUM_CH-1:0] req_elig;
   logic [NUM_CH-1:0] grant_oh;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   int                cand;
   logic [IDX_W-1:0]  cand_idx;

   assign req_elig = req_vld & ~mask;
   assign grant_oh = NUM_CH'(1) << grant;

   // Winner search: scan upward from the channel after the last grant, with wrap.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
`ifdef MEM_ARB_CH0_PRIO_EN
      if (req_elig[0]) begin
         win_found = 1'b1;
         win_idx   = '0;
      end
`endif
      for (int k = 1; k <= NUM_CH; k++) begin
         cand     = (int'(last_grant) + k) % NUM_CH;
         cand_idx = IDX_W'(cand);
`ifdef MEM_ARB_CH0_PRIO_EN
         if (!win_found && (cand_idx != '0) && req_elig[cand_idx]) begin
`else
         if (!win_found && req_elig[cand_idx]) begin
`endif
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Sequencer with registered memory-side and response-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         last_grant  <= IDX_W'(NUM_CH - 1);
         gnt_rd      <= 1'b0;
         mask        <= '0;
         wait_cnt    <= '0;
         rsp_vld     <= '0;
         rsp_rd_data <= '0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               mask <= '0;
               if (win_found) begin
                  grant       <= win_idx;
                  gnt_rd      <= req_rd[win_idx];
                  mem_addr    <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                  mem_wr_data <= req_wr_data[int'(win_idx)*DATA_W +: DATA_W];
                  mem_en      <= 1'b1;
                  mem_we      <= ~req_rd[win_idx];
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (gnt_rd) begin
                  wait_cnt <= CNT_W'(RD_LAT - 1);
                  state    <= WAIT;
               end else begin
                  rsp_vld <= grant_oh;
                  state   <= RESP;
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  rsp_rd_data <= mem_rd_data;
                  rsp_vld     <= grant_oh;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               rsp_vld    <= '0;
               last_grant <= grant;
               mask       <= grant_oh;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed literal scenarios plus a randomized
// phase, all compared every cycle against a timeline-based reference model.
module tb_mem_req_arbiter;
   localparam int NUM_CH = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 1;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic [NUM_CH-1:0]        req_vld;
   logic [NUM_CH-1:0]        req_rd;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_wr_data;
   logic [NUM_CH-1:0]        rsp_vld;
   logic [DATA_W-1:0]        rsp_rd_data;
   logic                     mem_en;
   logic                     mem_we;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wr_data;
   logic [DATA_W-1:0]        mem_rd_data;

   mem_req_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rd(req_rd), .req_addr(req_addr),
      .req_wr_data(req_wr_data), .rsp_vld(rsp_vld), .rsp_rd_data(rsp_rd_data), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // memory contents: device side (written by observed DUT writes) and model side
   logic [DATA_W-1:0] dev_mem   [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];

   function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
      return DATA_W'(a * 32'h9E3779B1 + 32'h1357);
   endfunction

   // reference model: transaction timeline measured in clock edges
   int e_next = 0, acc_e = -100, rsp_e = -100, free_e = 0, mask_e = -100;
   int mask_ch = 0, last_ch = NUM_CH - 1, m_ch = 0;
   bit m_rd = 1'b0;
   logic [DATA_W-1:0] m_rdval;
   logic [NUM_CH-1:0] exp_rsp;
   logic              exp_en, exp_we;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wdata, exp_rdata;

   // bench-side requester / memory-device state
   int  tcnt = 0;
   int  rd_due = -1;
   logic [DATA_W-1:0] rd_val;
   bit  hold_all = 1'b0;
   int  glog[$];

   function automatic bit eligible(input int c, input bit use_mask);
      return req_vld[c] && !(use_mask && c == mask_ch);
   endfunction

   function automatic int arbitrate(input bit use_mask);
`ifdef MEM_ARB_CH0_PRIO_EN
      if (eligible(0, use_mask)) return 0;
`endif
      for (int k = 1; k <= NUM_CH; k++) begin
         int c;
         c = (last_ch + k) % NUM_CH;
`ifdef MEM_ARB_CH0_PRIO_EN
         if (c != 0 && eligible(c, use_mask)) return c;
`else
         if (eligible(c, use_mask)) return c;
`endif
      end
      return -1;
   endfunction

   task automatic model_reset();
      free_e = e_next; acc_e = -100; rsp_e = -100; mask_e = -100;
      last_ch = NUM_CH - 1;
      exp_rsp = '0; exp_en = 1'b0; exp_we = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
   endtask

   // predict DUT outputs after the coming rising edge from the current inputs
   task automatic predict();
      int e, w;
      e = e_next;
      if (e >= free_e) begin
         w = arbitrate(e == mask_e);
         if (w >= 0) begin
            acc_e = e; m_ch = w; m_rd = req_rd[w];
            exp_addr  = req_addr[w*ADDR_W +: ADDR_W];
            exp_wdata = req_wr_data[w*DATA_W +: DATA_W];
            rsp_e  = e + 1 + (m_rd ? RD_LAT : 0);
            free_e = rsp_e + 2;
            mask_e = rsp_e + 2;
            mask_ch = w; last_ch = w;
            if (m_rd) m_rdval = model_mem.exists(exp_addr) ? model_mem[exp_addr] : init_val(exp_addr);
         end
      end
      exp_en = (e == acc_e);
      exp_we = exp_en && !m_rd;
      exp_rsp = '0;
      if (e == rsp_e) begin
         exp_rsp = NUM_CH'(1) << m_ch;
         if (m_rd) exp_rdata = m_rdval;
         else model_mem[exp_addr] = exp_wdata;
      end
      e_next++;
   endtask

   task automatic tick();
      @(negedge clk);
      tcnt++;
      chk("rsp_vld", rsp_vld, exp_rsp);
      chk("mem_en", mem_en, exp_en);
      chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wr_data", mem_wr_data, exp_wdata);
      chk("rsp_rd_data", rsp_rd_data, exp_rdata);
      if (mem_en && mem_we) dev_mem[mem_addr] = mem_wr_data;
      if (mem_en && !mem_we) begin
         rd_due = tcnt + RD_LAT;
         rd_val = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
      end
      mem_rd_data = (tcnt == rd_due) ? rd_val : DATA_W'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
         if (rsp_vld[i]) begin
            glog.push_back(i);
            if (!hold_all) req_vld[i] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      predict();
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_vld", rsp_vld, '0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wr_data", mem_wr_data, '0);
      chk("rst_rsp_rd_data", rsp_rd_data, '0);
      req_vld = '0; hold_all = 1'b0; rd_due = -1;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_req(input int ch, input bit rd, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      req_rd[ch] = rd;
      req_addr[ch*ADDR_W +: ADDR_W] = a;
      req_wr_data[ch*DATA_W +: DATA_W] = d;
      req_vld[ch] = 1'b1;
   endtask

   task automatic check_order(input string name, input int exp_q[$]);
      chk({name, "_count"}, 64'(glog.size() >= exp_q.size()), 64'd1);
      foreach (exp_q[i]) chk({name, "_order"}, 64'((i < glog.size()) ? glog[i] : -1), 64'(exp_q[i]));
      for (int i = 1; i < glog.size(); i++) chk({name, "_no_repeat"}, 64'(glog[i] == glog[i-1]), 64'd0);
   endtask

   task automatic drain();
      req_vld = '0; hold_all = 1'b0;
      repeat (8) cyc();
   endtask

   initial begin
      int exp_q[$];
      req_vld = '0; req_rd = '0; req_addr = '0; req_wr_data = '0; mem_rd_data = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // single write on channel 2
      set_req(2, 1'b0, 32'h10, 32'hDEADBEEF);
      cyc();
      chk("w_mem_en", mem_en, 1'b1);
      chk("w_mem_we", mem_we, 1'b1);
      chk("w_mem_addr", mem_addr, 32'h10);
      chk("w_mem_wr_data", mem_wr_data, 32'hDEADBEEF);
      cyc();
      chk("w_rsp_vld", rsp_vld, 4'b0100);
      repeat (3) cyc();

      // single read on channel 1
      dev_mem[32'h20] = 32'h12345678;
      model_mem[32'h20] = 32'h12345678;
      set_req(1, 1'b1, 32'h20, 32'h0);
      cyc();
      chk("r_mem_en", mem_en, 1'b1);
      chk("r_mem_we", mem_we, 1'b0);
      cyc();
      cyc();
      chk("r_rsp_vld", rsp_vld, 4'b0010);
      chk("r_rsp_rd_data", rsp_rd_data, 32'h12345678);
      repeat (3) cyc();

      do_reset();
      glog.delete();
      hold_all = 1'b1;
`ifdef MEM_ARB_CH0_PRIO_EN
      set_req(0, 1'b0, 32'h1, 32'hA0);
      set_req(3, 1'b0, 32'h2, 32'hA3);
      repeat (12) cyc();
      exp_q = '{0, 3, 0};
      check_order("prio", exp_q);
`else
      for (int i = 0; i < NUM_CH; i++) set_req(i, 1'b0, ADDR_W'(i), DATA_W'(32'hB0 + i));
      repeat (16) cyc();
      exp_q = '{0, 1, 2, 3, 0};
      check_order("rr", exp_q);
`endif
      drain();

      // randomized traffic, including occasional early request withdrawal
      repeat (3000) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!req_vld[i]) begin
               req_rd[i] = 1'($urandom);
               req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
               req_wr_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
               if ($urandom_range(0, 3) == 0) req_vld[i] = 1'b1;
            end else if ($urandom_range(0, 63) == 0) begin
               req_vld[i] = 1'b0;
            end
         end
         cyc();
      end
      drain();

      // reset in the middle of a read's WAIT phase
      set_req(2, 1'b1, 32'h3, 32'h0);
      cyc();
      chk("rw_mem_en", mem_en, 1'b1);
      cyc();
      do_reset();
      glog.delete();
      for (int i = 0; i < NUM_CH; i++) set_req(i, 1'b0, ADDR_W'(32'h40 + i), DATA_W'(i));
      repeat (6) cyc();
      chk("post_rst_first_grant", 64'((glog.size() > 0) ? glog[0] : -1), 64'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
